// File: rtl/mux_rr_pkg.sv
// Shared helpers for the round-robin registered selector: index-width function
// and reset constants for the data and index registers.
package mux_rr_pkg;

  function automatic int idx_largura(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int RESET_DADO   = 0;
  localparam int RESET_INDICE = 0;

endpackage

// File: rtl/arbitro_rr.sv
// Round-robin arbiter with pointer register; optional burst lock when
// MUX_RR_TRAVA_EN is defined.
module arbitro_rr
  import mux_rr_pkg::*;
#(
  parameter  int CANAIS = 2,
  localparam int IDX    = idx_largura(CANAIS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CANAIS-1:0] i_validos,
  input  logic              i_aceite,
  input  logic [CANAIS-1:0] i_ultimos,
  output logic [CANAIS-1:0] o_concessao,
  output logic [IDX-1:0]    o_indice
);

  logic [IDX-1:0] r_ptr;
  logic [IDX-1:0] w_vencedor;
  logic [IDX-1:0] w_prox;
  logic [IDX-1:0] w_cand;
  logic           w_achou;
  logic           w_ok;
  logic           w_transfer;

`ifdef MUX_RR_TRAVA_EN
  logic r_trava;
`else
  logic w_unused_ultimos;
  assign w_unused_ultimos = ^i_ultimos;
`endif

  // Grants are suppressed while reset is asserted, even though aceite is high.
  assign w_ok = i_aceite && rst_n;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    w_achou    = 1'b0;
    w_vencedor = r_ptr;
    w_cand     = r_ptr;
    for (int k = 0; k < CANAIS; k++) begin
      w_cand = IDX'((int'(r_ptr) + k) % CANAIS);
      if (!w_achou && i_validos[w_cand]) begin
        w_achou    = 1'b1;
        w_vencedor = w_cand;
      end
    end
`ifdef MUX_RR_TRAVA_EN
    if (r_trava) begin
      w_achou    = i_validos[r_ptr];
      w_vencedor = r_ptr;
    end
`endif
  end

  always_comb begin
    o_concessao = '0;
    for (int i = 0; i < CANAIS; i++) begin
      o_concessao[i] = w_ok && w_achou && (w_vencedor == IDX'(i));
    end
  end

  assign o_indice   = w_vencedor;
  assign w_transfer = |o_concessao;
  assign w_prox     = (w_vencedor == IDX'(CANAIS - 1)) ? '0 : w_vencedor + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      r_ptr <= IDX'(RESET_INDICE);
`ifdef MUX_RR_TRAVA_EN
      r_trava <= 1'b0;
`endif
    end else if (w_transfer) begin
`ifdef MUX_RR_TRAVA_EN
      r_trava <= !i_ultimos[w_vencedor];
      r_ptr   <= i_ultimos[w_vencedor] ? w_prox : w_vencedor;
`else
      r_ptr <= w_prox;
`endif
    end
  end

endmodule

// File: rtl/mux_rr_registrado.sv
// N-channel round-robin selector with valid/ready handshakes and a registered
// output stage. Burst lock is enabled by defining MUX_RR_TRAVA_EN.
module mux_rr_registrado
  import mux_rr_pkg::*;
#(
  parameter  int LARGURA = 3,
  parameter  int CANAIS  = 2,
  localparam int IDX     = idx_largura(CANAIS)
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic [CANAIS*LARGURA-1:0] Entradas,
  input  logic [CANAIS-1:0]         Validos,
  output logic [CANAIS-1:0]         Prontos,
  input  logic [CANAIS-1:0]         Ultimos,
  output logic [LARGURA-1:0]        Resultado,
  output logic                      ResultadoValido,
  input  logic                      ResultadoPronto,
  output logic [IDX-1:0]            Concessao
);

  logic               w_aceite;
  logic               w_transfer;
  logic [IDX-1:0]     w_indice;
  logic [LARGURA-1:0] w_dado;
  logic [LARGURA-1:0] r_resultado;
  logic               r_valido;
  logic [IDX-1:0]     r_concessao;

  // The register may reload in the same cycle the consumer empties it.
  assign w_aceite = !r_valido || ResultadoPronto;

  arbitro_rr #(.CANAIS(CANAIS)) u_arbitro (
    .clk        (Clock),
    .rst_n      (Reset_n),
    .i_validos  (Validos),
    .i_aceite   (w_aceite),
    .i_ultimos  (Ultimos),
    .o_concessao(Prontos),
    .o_indice   (w_indice)
  );

  assign w_transfer = |Prontos;

  always_comb begin
    w_dado = '0;
    for (int i = 0; i < CANAIS; i++) begin
      if (Prontos[i]) w_dado = Entradas[i*LARGURA +: LARGURA];
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_resultado <= LARGURA'(RESET_DADO);
      r_concessao <= IDX'(RESET_INDICE);
      r_valido    <= 1'b0;
    end else if (w_transfer) begin
      r_resultado <= w_dado;
      r_concessao <= w_indice;
      r_valido    <= 1'b1;
    end else if (ResultadoPronto) begin
      r_valido <= 1'b0;
    end
  end

  assign Resultado       = r_resultado;
  assign ResultadoValido = r_valido;
  assign Concessao       = r_concessao;

endmodule

// File: tb/tb_mux_rr_registrado.sv
// Directed bench for mux_rr_registrado: three instances (2, 3 and 4 channels)
// sharing one clock and reset; expectations follow MUX_RR_TRAVA_EN when defined.
module tb_mux_rr_registrado;

  logic clk;
  logic rst_n;

  // 2 channels
  logic [5:0] e2;
  logic [1:0] v2, p2, ult2;
  logic [2:0] r2;
  logic       rv2, rp2;
  logic [0:0] c2;

  // 4 channels
  logic [11:0] e4;
  logic [3:0]  v4, p4, ult4;
  logic [2:0]  r4;
  logic        rv4, rp4;
  logic [1:0]  c4;

  // 3 channels
  logic [8:0] e3;
  logic [2:0] v3, p3, ult3;
  logic [2:0] r3;
  logic       rv3, rp3;
  logic [1:0] c3;

  int n_checks = 0;
  int n_errors = 0;

  mux_rr_registrado #(.LARGURA(3), .CANAIS(2)) u_dut2 (
    .Clock(clk), .Reset_n(rst_n), .Entradas(e2), .Validos(v2), .Prontos(p2),
    .Ultimos(ult2), .Resultado(r2), .ResultadoValido(rv2),
    .ResultadoPronto(rp2), .Concessao(c2)
  );

  mux_rr_registrado #(.LARGURA(3), .CANAIS(4)) u_dut4 (
    .Clock(clk), .Reset_n(rst_n), .Entradas(e4), .Validos(v4), .Prontos(p4),
    .Ultimos(ult4), .Resultado(r4), .ResultadoValido(rv4),
    .ResultadoPronto(rp4), .Concessao(c4)
  );

  mux_rr_registrado #(.LARGURA(3), .CANAIS(3)) u_dut3 (
    .Clock(clk), .Reset_n(rst_n), .Entradas(e3), .Validos(v3), .Prontos(p3),
    .Ultimos(ult3), .Resultado(r3), .ResultadoValido(rv3),
    .ResultadoPronto(rp3), .Concessao(c3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [0:0] exp_c6 [4];

  initial begin
    rst_n = 1'b0;
    e2 = '0; v2 = '1; ult2 = '1; rp2 = 1'b1;
    e4 = '0; v4 = '1; ult4 = '1; rp4 = 1'b1;
    e3 = '0; v3 = '1; ult3 = '1; rp3 = 1'b1;

    // Reset state and Prontos gating during reset
    #1;
    check("rst_prontos2", p2, 0);
    check("rst_prontos4", p4, 0);
    check("rst_prontos3", p3, 0);
    check("rst_resultado2", r2, 0);
    check("rst_valido2", rv2, 0);
    check("rst_concessao2", c2, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    v2 = '0; v4 = '0; v3 = '0;

    // Test 1: single request on channel 0 of the 2-channel instance
    e2 = {3'b000, 3'b111};
    v2 = 2'b01;
    #1 check("t1_prontos", p2, 2'b01);
    tick();
    check("t1_resultado", r2, 3'b111);
    check("t1_valido", rv2, 1);
    check("t1_concessao", c2, 0);
    v2 = '0;
    tick();
    check("t1_esvaziou", rv2, 0);

    // Test 2: all four channels requesting, consumer always ready
    e4 = {3'd4, 3'd3, 3'd2, 3'd1};
    v4 = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1 check("t2_prontos", p4, 32'(1) << (k % 4));
      tick();
      check("t2_concessao", c4, k % 4);
      check("t2_resultado", r4, (k % 4) + 1);
      check("t2_valido", rv4, 1);
    end

    // Test 3: backpressure freezes the held word and the pointer
    rp4 = 1'b0;
    #1 check("t3_prontos_bp", p4, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_resultado_hold", r4, 4);
      check("t3_concessao_hold", c4, 3);
      check("t3_valido_hold", rv4, 1);
      check("t3_prontos_hold", p4, 0);
    end
    rp4 = 1'b1;
    #1 check("t3_prontos_release", p4, 4'b0001);
    tick();
    check("t3_resultado_new", r4, 1);
    check("t3_concessao_new", c4, 0);
    check("t3_valido_new", rv4, 1);
    v4 = '0;

    // Test 4: 3-channel wrap from channel 2 back to 0
    e3 = {3'd5, 3'd6, 3'd7};
    v3 = 3'b100;
    #1 check("t4_prontos_c2", p3, 3'b100);
    tick();
    check("t4_concessao_c2", c3, 2);
    check("t4_resultado_c2", r3, 5);
    v3 = 3'b001;
    #1 check("t4_prontos_c0", p3, 3'b001);
    tick();
    check("t4_concessao_c0", c3, 0);
    check("t4_resultado_c0", r3, 7);
    v3 = 3'b111;
    #1 check("t4_prontos_ptr1", p3, 3'b010);
    tick();
    check("t4_concessao_c1", c3, 1);
    check("t4_resultado_c1", r3, 6);

    // Test 5: asynchronous reset with a word held (pointer was at 2)
    v3 = '0;
    rp3 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t5_valido_rst", rv3, 0);
    check("t5_resultado_rst", r3, 0);
    check("t5_concessao_rst", c3, 0);
    #1 rst_n = 1'b1;
    v3 = 3'b110;
    rp3 = 1'b1;
    #1 check("t5_prontos_after", p3, 3'b010);
    tick();
    check("t5_concessao_after", c3, 1);
    check("t5_resultado_after", r3, 6);
    v3 = '0;

    // Test 6: burst on channel 1 while channel 0 keeps requesting
    e2 = {3'b010, 3'b101};
    v2 = 2'b01;
    ult2 = 2'b11;
    tick();
    check("t6_prep_concessao", c2, 0);
`ifdef MUX_RR_TRAVA_EN
    exp_c6[0] = 1'b1; exp_c6[1] = 1'b1; exp_c6[2] = 1'b1; exp_c6[3] = 1'b0;
`else
    exp_c6[0] = 1'b1; exp_c6[1] = 1'b0; exp_c6[2] = 1'b1; exp_c6[3] = 1'b0;
`endif
    v2 = 2'b11;
    for (int k = 0; k < 4; k++) begin
      ult2 = (k < 2) ? 2'b01 : 2'b11;
      #1 check("t6_prontos", p2, exp_c6[k] ? 2'b10 : 2'b01);
      tick();
      check("t6_concessao", c2, exp_c6[k]);
      check("t6_resultado", r2, exp_c6[k] ? 3'b010 : 3'b101);
    end
    v2 = '0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
